// File: rtl/usb_fs_rx_phy_if.sv
// Receive-side bundle of the full-speed USB PHY: raw D+/D- in, byte stream and framing strobes out.
interface usb_fs_rx_phy_if;
  logic       usb_d_p;
  logic       usb_d_n;
  logic       rx_active;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_eop;
  logic       rx_error;
  logic       rx_crc_ok;

  modport master (
    input  usb_d_p, usb_d_n,
    output rx_active, rx_data, rx_valid, rx_eop, rx_error, rx_crc_ok
  );

  modport slave (
    output usb_d_p, usb_d_n,
    input  rx_active, rx_data, rx_valid, rx_eop, rx_error, rx_crc_ok
  );
endinterface

// File: rtl/usb_fs_rx_phy.sv
// USB full-speed receive front end: 4x oversampled DPLL, NRZI decode, unstuffing, SYNC/EOP framing.
// Define USB_RX_CRC16_EN to add the CRC16 residual check reported on rx_crc_ok.
//
// state | meaning
// IDLE  | line idle, waiting for the first K of SYNC
// SYNC  | counting SYNC zeros, waiting for the terminating one
// DATA  | deserialising unstuffed bits into LSB-first bytes
// EOP   | SE0 seen, waiting for J to close the packet
// ABORT | error reported, waiting for SE0 then J (or eight J samples)
module usb_fs_rx_phy #(
  parameter int CLKS_PER_BIT   = 4,
  parameter int SYNC_MIN_ZEROS = 5
) (
  input  logic             clk48,
  input  logic             rst,
  usb_fs_rx_phy_if.master  bus
);

  localparam int PW = $clog2(CLKS_PER_BIT) + 1;
  localparam int ZW = $clog2(SYNC_MIN_ZEROS + 1) + 1;
  localparam logic [PW-1:0] PH_SAMPLE = PW'(CLKS_PER_BIT / 2);
  localparam logic [PW-1:0] PH_LAST   = PW'(CLKS_PER_BIT - 1);
  localparam logic [ZW-1:0] ZMIN      = ZW'(SYNC_MIN_ZEROS);

  localparam logic [1:0] LS_SE0 = 2'b00;
  localparam logic [1:0] LS_K   = 2'b01;
  localparam logic [1:0] LS_J   = 2'b10;
  localparam logic [1:0] LS_SE1 = 2'b11;

  typedef enum logic [2:0] {ST_IDLE, ST_SYNC, ST_DATA, ST_EOP, ST_ABORT} state_t;

  state_t        state_q, state_d;
  logic [1:0]    meta_q, line_q, line_prev_q;
  logic [1:0]    prev_q, prev_d;
  logic [PW-1:0] phase_q, phase_d, phase_cur;
  logic          sample, nrzi_one;
  logic [ZW-1:0] zero_cnt_q, zero_cnt_d;
  logic [2:0]    ones_cnt_q, ones_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [2:0]    abort_j_q, abort_j_d;
  logic [6:0]    shreg_q, shreg_d;
  logic          partial_q, partial_d;
  logic          abort_se0_q, abort_se0_d;
  logic          rx_active_q, rx_active_d;
  logic          rx_valid_q, rx_valid_d;
  logic          rx_eop_q, rx_eop_d;
  logic          rx_error_q, rx_error_d;
  logic [7:0]    rx_data_q, rx_data_d;
`ifdef USB_RX_CRC16_EN
  logic [15:0]   crc_q, crc_d;
  logic          crc_ok_q, crc_ok_d;
  logic          pid_done_q, pid_done_d;
`endif

  // Phase is 0 in the cycle a line change is seen, so the sample lands mid-bit for 3..5 clk bits.
  always_comb begin
    phase_cur = (line_q != line_prev_q) ? '0 : phase_q;
    phase_d   = (phase_cur == PH_LAST) ? '0 : phase_cur + PW'(1);
    sample    = (phase_cur == PH_SAMPLE);
    nrzi_one  = (line_q == prev_q);
  end

  always_ff @(posedge clk48) begin
    if (rst) begin
      meta_q      <= LS_J;
      line_q      <= LS_J;
      line_prev_q <= LS_J;
      phase_q     <= '0;
      state_q     <= ST_IDLE;
      prev_q      <= LS_J;
      zero_cnt_q  <= '0;
      ones_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      abort_j_q   <= '0;
      shreg_q     <= '0;
      partial_q   <= 1'b0;
      abort_se0_q <= 1'b0;
      rx_active_q <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_eop_q    <= 1'b0;
      rx_error_q  <= 1'b0;
      rx_data_q   <= '0;
`ifdef USB_RX_CRC16_EN
      crc_q       <= '1;
      crc_ok_q    <= 1'b0;
      pid_done_q  <= 1'b0;
`endif
    end else begin
      meta_q      <= {bus.usb_d_p, bus.usb_d_n};
      line_q      <= meta_q;
      line_prev_q <= line_q;
      phase_q     <= phase_d;
      state_q     <= state_d;
      prev_q      <= prev_d;
      zero_cnt_q  <= zero_cnt_d;
      ones_cnt_q  <= ones_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      abort_j_q   <= abort_j_d;
      shreg_q     <= shreg_d;
      partial_q   <= partial_d;
      abort_se0_q <= abort_se0_d;
      rx_active_q <= rx_active_d;
      rx_valid_q  <= rx_valid_d;
      rx_eop_q    <= rx_eop_d;
      rx_error_q  <= rx_error_d;
      rx_data_q   <= rx_data_d;
`ifdef USB_RX_CRC16_EN
      crc_q       <= crc_d;
      crc_ok_q    <= crc_ok_d;
      pid_done_q  <= pid_done_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    zero_cnt_d  = zero_cnt_q;
    ones_cnt_d  = ones_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    partial_d   = partial_q;
    abort_se0_d = (state_q == ST_ABORT) ? abort_se0_q : 1'b0;
    abort_j_d   = (state_q == ST_ABORT) ? abort_j_q : 3'd0;
    rx_active_d = rx_active_q;
    rx_valid_d  = 1'b0;
    rx_eop_d    = 1'b0;
    rx_error_d  = 1'b0;
    rx_data_d   = rx_data_q;
`ifdef USB_RX_CRC16_EN
    crc_d       = crc_q;
    crc_ok_d    = crc_ok_q;
    pid_done_d  = pid_done_q;
`endif
    if (sample) begin
      case (state_q)
        ST_IDLE: begin
          if (line_q == LS_K) begin
            state_d    = ST_SYNC;
            prev_d     = LS_K;
            zero_cnt_d = ZW'(1);
          end
        end
        ST_SYNC: begin
          if (line_q == LS_SE0) begin
            state_d = ST_IDLE;
          end else if (line_q == LS_SE1) begin
            rx_error_d = 1'b1;
            state_d    = ST_ABORT;
          end else begin
            prev_d = line_q;
            if (!nrzi_one) begin
              if (zero_cnt_q != '1) zero_cnt_d = zero_cnt_q + ZW'(1);
            end else if (zero_cnt_q >= ZMIN) begin
              state_d     = ST_DATA;
              rx_active_d = 1'b1;
              ones_cnt_d  = '0;
              bit_cnt_d   = '0;
`ifdef USB_RX_CRC16_EN
              crc_d       = '1;
              pid_done_d  = 1'b0;
`endif
            end else begin
              rx_error_d = 1'b1;
              state_d    = ST_ABORT;
            end
          end
        end
        ST_DATA: begin
          if (line_q == LS_SE1) begin
            rx_error_d  = 1'b1;
            rx_active_d = 1'b0;
            state_d     = ST_ABORT;
          end else if (line_q == LS_SE0) begin
            state_d   = ST_EOP;
            partial_d = (bit_cnt_q != 3'd0);
          end else begin
            prev_d = line_q;
            // A seventh consecutive one is a stuffing violation; a zero here is the stuff bit.
            if (ones_cnt_q == 3'd6) begin
              if (nrzi_one) begin
                rx_error_d  = 1'b1;
                rx_active_d = 1'b0;
                state_d     = ST_ABORT;
              end else begin
                ones_cnt_d = '0;
              end
            end else begin
              ones_cnt_d = nrzi_one ? ones_cnt_q + 3'd1 : 3'd0;
              shreg_d    = {nrzi_one, shreg_q[6:1]};
              bit_cnt_d  = bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                rx_data_d  = {nrzi_one, shreg_q};
                rx_valid_d = 1'b1;
              end
`ifdef USB_RX_CRC16_EN
              if (bit_cnt_q == 3'd7) pid_done_d = 1'b1;
              if (pid_done_q)
                crc_d = {crc_q[14:0], 1'b0} ^ ((nrzi_one ^ crc_q[15]) ? 16'h8005 : 16'h0000);
`endif
            end
          end
        end
        ST_EOP: begin
          if (line_q == LS_J) begin
            rx_eop_d    = 1'b1;
            rx_error_d  = partial_q;
            rx_active_d = 1'b0;
            state_d     = ST_IDLE;
`ifdef USB_RX_CRC16_EN
            crc_ok_d    = (crc_q == 16'h800D);
`endif
          end else if (line_q != LS_SE0) begin
            rx_error_d  = 1'b1;
            rx_active_d = 1'b0;
            state_d     = ST_ABORT;
          end
        end
        ST_ABORT: begin
          if (line_q == LS_SE0) begin
            abort_se0_d = 1'b1;
            abort_j_d   = '0;
          end else if (line_q == LS_J) begin
            if (abort_se0_q || abort_j_q == 3'd7) state_d = ST_IDLE;
            else abort_j_d = abort_j_q + 3'd1;
          end else begin
            abort_j_d = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign bus.rx_active = rx_active_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.rx_eop    = rx_eop_q;
  assign bus.rx_error  = rx_error_q;
`ifdef USB_RX_CRC16_EN
  assign bus.rx_crc_ok = crc_ok_q;
`else
  assign bus.rx_crc_ok = 1'b0;
`endif

endmodule
